// File: rtl/mandelbrot_scan_engine.sv
// Mandelbrot pixel engine: scans an interleaved column subset, iterates z = z^2 + c in
// signed fixed point, and posts each pixel's escape count through a valid/ready write port.
module mandelbrot_scan_engine #(
  parameter int WIDTH    = 27,
  parameter int FRAC     = 23,
  parameter int ITER_W   = 12,
  parameter int X_RES    = 640,
  parameter int Y_RES    = 480,
  parameter int X_START  = 0,
  parameter int X_STRIDE = 1,
  parameter int ADDR_W   = 19
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic signed [WIDTH-1:0]  cr_init,
  input  logic signed [WIDTH-1:0]  ci_init,
  input  logic signed [WIDTH-1:0]  dx,
  input  logic signed [WIDTH-1:0]  dy,
  input  logic [ITER_W-1:0]        max_iter,
  output logic                     wr_valid,
  input  logic                     wr_ready,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [ITER_W-1:0]        wr_data,
  output logic                     busy,
  output logic                     frame_done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ITER  = 3'd2,
    ST_WRITE = 3'd3,
    ST_NEXT  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [WIDTH-1:0] FX_TWO  = WIDTH'(32'd2) << FRAC;
  localparam logic [WIDTH:0]   FX_FOUR = (WIDTH+1)'(32'd4) << FRAC;

  // Fixed-point product: keep the true sign bit and the in-format magnitude bits.
  function automatic logic signed [WIDTH-1:0] fx_mul(input logic signed [WIDTH-1:0] a,
                                                     input logic signed [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] p;
    p = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    return {p[2*WIDTH-1], p[WIDTH+FRAC-2:FRAC]};
  endfunction

  function automatic logic [WIDTH-1:0] fx_abs(input logic signed [WIDTH-1:0] a);
    return a[WIDTH-1] ? (-a) : a;
  endfunction

  state_t                    state_r, state_next_s;
  logic signed [WIDTH-1:0]   zr_r, zi_r, cr_r, ci_r;
  logic [ITER_W-1:0]         iter_r;
  logic [ADDR_W-1:0]         x_r, y_r;
  logic                      wr_valid_r, busy_r, frame_done_r;
  logic [ADDR_W-1:0]         wr_addr_r;
  logic [ITER_W-1:0]         wr_data_r;

  logic signed [WIDTH-1:0]   zr_sq_s, zi_sq_s, zri_s, zr_next_s, zi_next_s;
  logic [WIDTH:0]            mag_sum_s;
  logic                      esc_s, row_end_s, last_row_s;
  logic [ADDR_W:0]           x_step_s;
  logic [ADDR_W-1:0]         addr_s;

  assign zr_sq_s   = fx_mul(zr_r, zr_r);
  assign zi_sq_s   = fx_mul(zi_r, zi_r);
  assign zri_s     = fx_mul(zr_r, zi_r);
  assign zr_next_s = zr_sq_s - zi_sq_s + cr_r;
  assign zi_next_s = (zri_s <<< 1) + ci_r;
  // Magnitude terms catch large z whose squares have already wrapped.
  assign mag_sum_s = {1'b0, zr_sq_s} + {1'b0, zi_sq_s};
  assign esc_s     = (fx_abs(zr_r) > FX_TWO) || (fx_abs(zi_r) > FX_TWO) ||
                     (mag_sum_s > FX_FOUR) || (iter_r >= max_iter);
  assign x_step_s   = {1'b0, x_r} + (ADDR_W+1)'(X_STRIDE);
  assign row_end_s  = (x_step_s >= (ADDR_W+1)'(X_RES));
  assign last_row_s = (y_r == ADDR_W'(Y_RES - 1));
  assign addr_s     = y_r * ADDR_W'(X_RES) + x_r;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_next_s;
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:  if (start) state_next_s = ST_INIT; else state_next_s = ST_IDLE;
      ST_INIT:  state_next_s = ST_ITER;
      ST_ITER:  if (esc_s) state_next_s = ST_WRITE; else state_next_s = ST_ITER;
      ST_WRITE: if (wr_ready) state_next_s = ST_NEXT; else state_next_s = ST_WRITE;
      ST_NEXT:  if (row_end_s && last_row_s) state_next_s = ST_DONE; else state_next_s = ST_INIT;
      ST_DONE:  state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Datapath: scan position, c, z, iteration count and the write port registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      zr_r <= {WIDTH{1'b0}};  zi_r <= {WIDTH{1'b0}};
      cr_r <= {WIDTH{1'b0}};  ci_r <= {WIDTH{1'b0}};
      iter_r <= {ITER_W{1'b0}};
      x_r <= {ADDR_W{1'b0}};  y_r <= {ADDR_W{1'b0}};
      wr_valid_r <= 1'b0;
      wr_addr_r  <= {ADDR_W{1'b0}};
      wr_data_r  <= {ITER_W{1'b0}};
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      busy_r       <= (state_next_s != ST_IDLE);
      frame_done_r <= (state_next_s == ST_DONE);
      case (state_r)
        ST_IDLE: if (start) begin
          x_r  <= ADDR_W'(X_START);
          y_r  <= {ADDR_W{1'b0}};
          cr_r <= cr_init;
          ci_r <= ci_init;
        end
        ST_INIT: begin
          zr_r <= {WIDTH{1'b0}};
          zi_r <= {WIDTH{1'b0}};
          iter_r <= {ITER_W{1'b0}};
        end
        ST_ITER: if (esc_s) begin
          wr_addr_r  <= addr_s;
          wr_data_r  <= iter_r;
          wr_valid_r <= 1'b1;
        end else begin
          zr_r   <= zr_next_s;
          zi_r   <= zi_next_s;
          iter_r <= iter_r + {{(ITER_W-1){1'b0}}, 1'b1};
        end
        ST_WRITE: if (wr_ready) wr_valid_r <= 1'b0;
        ST_NEXT: if (!row_end_s) begin
          x_r  <= x_step_s[ADDR_W-1:0];
          cr_r <= cr_r + dx;
        end else begin
          x_r  <= ADDR_W'(X_START);
          cr_r <= cr_init;
          if (!last_row_s) begin
            y_r  <= y_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            ci_r <= ci_r - dy;
          end
        end
        default: ;
      endcase
    end
  end

  assign wr_valid   = wr_valid_r;
  assign wr_addr    = wr_addr_r;
  assign wr_data    = wr_data_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_mandelbrot_scan_engine.sv
// Bench: single-pixel engine for escape-count cases, 4x2 strided engine for scan order,
// back-pressure, reset abort and start filtering; expectations come from a scoreboard.
module tb_mandelbrot_scan_engine;
  localparam int W  = 27;
  localparam int FR = 23;
  localparam int IW = 12;
  localparam int AW = 19;
  localparam longint ONE  = longint'(1) << FR;
  localparam longint HALF = longint'(1) << (FR - 1);
  localparam longint QTR  = longint'(1) << (FR - 2);

  typedef struct { logic [AW-1:0] addr; logic [IW-1:0] data; } exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic          start_a, valid_a, ready_a, busy_a, fd_a;
  logic [W-1:0]  cr_a, ci_a, dx_a, dy_a;
  logic [IW-1:0] mi_a, data_a;
  logic [AW-1:0] addr_a;
  logic          start_b, valid_b, ready_b, busy_b, fd_b;
  logic [W-1:0]  cr_b, ci_b, dx_b, dy_b;
  logic [IW-1:0] mi_b, data_b;
  logic [AW-1:0] addr_b;

  mandelbrot_scan_engine #(.X_RES(4), .Y_RES(2), .X_START(1), .X_STRIDE(2)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .cr_init(cr_a), .ci_init(ci_a),
    .dx(dx_a), .dy(dy_a), .max_iter(mi_a), .wr_valid(valid_a), .wr_ready(ready_a),
    .wr_addr(addr_a), .wr_data(data_a), .busy(busy_a), .frame_done(fd_a));

  mandelbrot_scan_engine #(.X_RES(1), .Y_RES(1)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .cr_init(cr_b), .ci_init(ci_b),
    .dx(dx_b), .dy(dy_b), .max_iter(mi_b), .wr_valid(valid_b), .wr_ready(ready_b),
    .wr_addr(addr_b), .wr_data(data_b), .busy(busy_b), .frame_done(fd_b));

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference escape count computed with wide integer arithmetic.
  function automatic int model_iter(input longint cr, input longint ci, input int mi);
    longint zr, zi, zr2, zi2, azr, azi, t;
    zr = 0; zi = 0;
    for (int it = 0; it <= mi; it++) begin
      zr2 = (zr * zr) >>> FR;
      zi2 = (zi * zi) >>> FR;
      azr = (zr < 0) ? -zr : zr;
      azi = (zi < 0) ? -zi : zi;
      if (azr > 2 * ONE || azi > 2 * ONE || zr2 + zi2 > 4 * ONE || it >= mi) return it;
      t  = zr2 - zi2 + cr;
      zi = 2 * ((zr * zi) >>> FR) + ci;
      zr = t;
    end
    return mi;
  endfunction

  task automatic chk_zero(input string tag, input logic v, input logic [AW-1:0] ad,
                          input logic [IW-1:0] d, input logic b, input logic f);
    check({tag, "_valid"}, v, 1'b0);
    check({tag, "_addr"}, ad, 0);
    check({tag, "_data"}, d, 0);
    check({tag, "_busy"}, b, 1'b0);
    check({tag, "_frame_done"}, f, 1'b0);
  endtask

  task automatic run_b(input string tag, input longint crv, input longint civ,
                       input int mi, input int exp_d);
    exp_t e;
    int   waited;
    e.addr = '0; e.data = IW'(exp_d);
    q_b.push_back(e);
    cr_b = W'(crv); ci_b = W'(civ); mi_b = IW'(mi); start_b = 1'b1;
    @(negedge clock); start_b = 1'b0;
    check({tag, "_busy"}, busy_b, 1'b1);
    waited = 0;
    while (valid_b !== 1'b1 && waited < 5000) begin @(negedge clock); waited++; end
    check({tag, "_latency"}, waited, exp_d + 2);
    if (valid_b === 1'b1 && q_b.size() > 0) begin
      e = q_b.pop_front();
      check({tag, "_addr"}, addr_b, e.addr);
      check({tag, "_data"}, data_b, e.data);
    end
    @(negedge clock);
    check({tag, "_drop"}, valid_b, 1'b0);
    check({tag, "_fd_next"}, fd_b, 1'b0);
    @(negedge clock);
    check({tag, "_fd_pulse"}, fd_b, 1'b1);
    @(negedge clock);
    check({tag, "_fd_end"}, fd_b, 1'b0);
    check({tag, "_idle"}, busy_b, 1'b0);
  endtask

  task automatic push_tile(input longint crv, input longint civ, input longint dxv,
                           input longint dyv, input int mi);
    exp_t e;
    for (int y = 0; y < 2; y++)
      for (int xi = 0; xi < 2; xi++) begin
        e.addr = AW'(y * 4 + 1 + 2 * xi);
        e.data = IW'(model_iter(crv + xi * dxv, civ - y * dyv, mi));
        q_a.push_back(e);
      end
  endtask

  task automatic start_a_frame(input longint crv, input longint civ, input longint dxv,
                               input longint dyv, input int mi);
    cr_a = W'(crv); ci_a = W'(civ); dx_a = W'(dxv); dy_a = W'(dyv); mi_a = IW'(mi);
    start_a = 1'b1;
    @(negedge clock); start_a = 1'b0;
  endtask

  task automatic collect_a(input string tag, input int n_pix, input int stall);
    exp_t e;
    int   waited;
    for (int p = 0; p < n_pix; p++) begin
      waited = 0;
      while (valid_a !== 1'b1 && waited < 5000) begin @(negedge clock); waited++; end
      check({tag, "_valid"}, valid_a, 1'b1);
      check({tag, "_queue"}, q_a.size() > 0, 1'b1);
      if (valid_a !== 1'b1 || q_a.size() == 0) return;
      e = q_a.pop_front();
      check({tag, "_addr"}, addr_a, e.addr);
      check({tag, "_data"}, data_a, e.data);
      if (p == 0 && stall > 0) begin
        for (int s = 0; s < stall; s++) begin
          @(negedge clock);
          check({tag, "_stall_valid"}, valid_a, 1'b1);
          check({tag, "_stall_addr"}, addr_a, e.addr);
          check({tag, "_stall_data"}, data_a, e.data);
        end
        ready_a = 1'b1;
      end
      @(negedge clock);
      check({tag, "_drop"}, valid_a, 1'b0);
    end
  endtask

  task automatic frame_end_a(input string tag, input bit start_in_done);
    check({tag, "_fd_next"}, fd_a, 1'b0);
    @(negedge clock);
    check({tag, "_fd_pulse"}, fd_a, 1'b1);
    check({tag, "_busy_done"}, busy_a, 1'b1);
    if (start_in_done) start_a = 1'b1;
    @(negedge clock); start_a = 1'b0;
    check({tag, "_fd_end"}, fd_a, 1'b0);
    check({tag, "_idle"}, busy_a, 1'b0);
    repeat (6) @(negedge clock);
    check({tag, "_stay_idle"}, busy_a, 1'b0);
    check({tag, "_no_extra"}, valid_a, 1'b0);
    check({tag, "_queue_empty"}, q_a.size(), 0);
  endtask

  initial begin
    int waited;
    reset = 1'b1;
    start_a = 1'b0; cr_a = '0; ci_a = '0; dx_a = '0; dy_a = '0; mi_a = '0; ready_a = 1'b1;
    start_b = 1'b0; cr_b = '0; ci_b = '0; dx_b = '0; dy_b = '0; mi_b = '0; ready_b = 1'b1;
    repeat (3) @(negedge clock);
    chk_zero("rst_a", valid_a, addr_a, data_a, busy_a, fd_a);
    chk_zero("rst_b", valid_b, addr_b, data_b, busy_b, fd_b);
    reset = 1'b0;
    @(negedge clock);

    run_b("c_zero", 0, 0, 1000, 1000);
    run_b("c_one", ONE, 0, 1000, 3);
    run_b("c_two", 2 * ONE, 0, 1000, 2);
    run_b("c_minus_two", -2 * ONE, 0, 30, 30);
    run_b("c_i_two", 0, 2 * ONE, 30, 2);

    // Strided 4x2 scan with a 10-cycle stall on the first pixel.
    push_tile(-HALF, HALF, HALF + QTR, QTR, 20);
    ready_a = 1'b0;
    start_a_frame(-HALF, HALF, HALF + QTR, QTR, 20);
    check("tile_busy", busy_a, 1'b1);
    collect_a("tile", 4, 10);
    frame_end_a("tile", 1'b0);

    // max_iter = 0 with start pulses mid-frame and in the DONE cycle.
    push_tile(ONE, 0, QTR, QTR, 0);
    start_a_frame(ONE, 0, QTR, QTR, 0);
    start_a = 1'b1;
    @(negedge clock); start_a = 1'b0;
    collect_a("mi0", 4, 0);
    frame_end_a("mi0", 1'b1);

    // Reset while iterating.
    start_a_frame(0, 0, ONE, ONE, 1000);
    repeat (4) @(negedge clock);
    check("rst_iter_busy", busy_a, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    chk_zero("rst_iter", valid_a, addr_a, data_a, busy_a, fd_a);
    reset = 1'b0;

    // Reset while a write is pending.
    ready_a = 1'b0;
    start_a_frame(0, 0, ONE, ONE, 0);
    waited = 0;
    while (valid_a !== 1'b1 && waited < 50) begin @(negedge clock); waited++; end
    check("rst_write_pending", valid_a, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    chk_zero("rst_write", valid_a, addr_a, data_a, busy_a, fd_a);
    reset = 1'b0; ready_a = 1'b1;
    @(negedge clock);

    // Fresh full frame after the aborts.
    push_tile(-ONE - HALF, ONE, ONE, HALF + QTR, 40);
    start_a_frame(-ONE - HALF, ONE, ONE, HALF + QTR, 40);
    collect_a("after_rst", 4, 0);
    frame_end_a("after_rst", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
